team_08_gpio_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the team_08 core logic, between the breakout-board GPIO input pins and the design's control logic. For each of WIDTH raw pins it synchronizes, debounces, produces a clean level plus one-cycle rise/fall pulses, and queues edge events to a valid/ready event port, one event per transfer. Lossless while the consumer keeps up; drops are flagged by a sticky overflow bit.

---
 rtl/team_08_gpio_conditioner_if.sv | 12 +
 rtl/team_08_gpio_conditioner.sv | 121 ++++++++++++
 tb/tb_team_08_gpio_conditioner.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/team_08_gpio_conditioner_if.sv
// Edge-event handshake port of the GPIO conditioner: one (idx, dir) event per valid/ready transfer.
interface team_08_gpio_conditioner_if #(
    parameter int IDX_W = 3
);
    logic             event_valid;
    logic             event_ready;
    logic [IDX_W-1:0] event_idx;
    logic             event_dir;

    modport master (output event_valid, output event_idx, output event_dir, input event_ready);
    modport slave  (input event_valid, input event_idx, input event_dir, output event_ready);
endinterface

// File: rtl/team_08_gpio_conditioner.sv
// Per-pin synchronizer + debouncer with edge pulses, per-channel pending slots and a
// single registered event slot drained lowest-index-first over a valid/ready port.
module team_08_gpio_conditioner #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 16,
    parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          raw_in,
    output logic [WIDTH-1:0]          level_out,
    output logic [WIDTH-1:0]          rise_pulse,
    output logic [WIDTH-1:0]          fall_pulse,
    team_08_gpio_conditioner_if.master evt,
    output logic                      overflow,
    input  logic                      clr_ovf
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] pend_q, pend_d, pdir_q, pdir_d;
    logic             ev_valid_q, ev_valid_d, ev_dir_q, ev_dir_d;
    logic [IDX_W-1:0] ev_idx_q, ev_idx_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] first, take, edge_v, set_v, drop, kept;
    logic             found, load;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Disabled or stable channels keep the counter at zero.
            if (en && (sync2_q[i] != level_q[i])) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        found    = 1'b0;
        first    = '0;
        ev_idx_d = ev_idx_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pend_q[i] && !found) begin
                found    = 1'b1;
                first[i] = 1'b1;
            end
        end

        load       = ~ev_valid_q | evt.event_ready;
        take       = load ? first : '0;
        ev_valid_d = load ? found : ev_valid_q;
        ev_dir_d   = (load && found) ? |(first & pdir_q) : ev_dir_q;
        if (load && found) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (first[i]) ev_idx_d = IDX_W'(i);
            end
        end

        // A slot being unloaded this edge is free to accept a new edge without overflow.
        kept   = pend_q & ~take;
        edge_v = rise_d | fall_d;
        drop   = edge_v & kept;
        set_v  = edge_v & ~kept;
        pend_d = kept | set_v;
        pdir_d = (pdir_q & ~set_v) | (rise_d & set_v);
        ovf_d  = (ovf_q & ~clr_ovf) | (|drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            pend_q     <= '0;
            pdir_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_idx_q   <= '0;
            ev_dir_q   <= 1'b0;
            ovf_q      <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            pend_q     <= pend_d;
            pdir_q     <= pdir_d;
            ev_valid_q <= ev_valid_d;
            ev_idx_q   <= ev_idx_d;
            ev_dir_q   <= ev_dir_d;
            ovf_q      <= ovf_d;
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level_out       = level_q;
    assign rise_pulse      = rise_q;
    assign fall_pulse      = fall_q;
    assign overflow        = ovf_q;
    assign evt.event_valid = ev_valid_q;
    assign evt.event_idx   = ev_idx_q;
    assign evt.event_dir   = ev_dir_q;
endmodule

// File: tb/tb_team_08_gpio_conditioner.sv
// Bench for team_08_gpio_conditioner: directed scenarios plus random pin activity,
// with a reference model feeding an event scoreboard drained by an independent monitor.
module tb_team_08_gpio_conditioner;
    localparam int W  = 8;
    localparam int DB = 4;

    typedef struct {
        int   idx;
        logic dir;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst, en, clr, rdy;
    logic [W-1:0] raw;
    logic [W-1:0] level_out, rise_pulse, fall_pulse;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    team_08_gpio_conditioner_if #(.IDX_W(3)) evt_if ();
    assign evt_if.event_ready = rdy;

    team_08_gpio_conditioner #(.WIDTH(W), .DB_CYCLES(DB), .IDX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .raw_in     (raw),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt        (evt_if),
        .overflow   (overflow),
        .clr_ovf    (clr)
    );

    always #5 clk = ~clk;

    // Reference model state: spec-level pin history, run lengths and event bookkeeping.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0, m_fall = '0;
    logic [W-1:0] m_pend = '0, m_pdir = '0;
    int           m_run [W];
    logic         m_v = 1'b0, m_ovf = 1'b0;
    ev_t          sbq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] nr, nf;
        int   pick;
        bit   dropped;
        ev_t  e;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
            m_pend = '0; m_pdir = '0; m_v = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            sbq.delete();
            return;
        end
        nr = '0;
        nf = '0;
        for (int i = 0; i < W; i++) begin
            if (!en || m_s2[i] == m_lvl[i]) m_run[i] = 0;
            else if (m_run[i] + 1 == DB) begin
                m_run[i] = 0;
                if (m_s2[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
            end else m_run[i]++;
        end
        if (!m_v || rdy) begin
            pick = -1;
            for (int i = 0; i < W; i++) if (m_pend[i] && pick < 0) pick = i;
            m_v = (pick >= 0);
            if (pick >= 0) begin
                e.idx = pick;
                e.dir = m_pdir[pick];
                m_pend[pick] = 1'b0;
                sbq.push_back(e);
            end
        end
        dropped = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (nr[i] || nf[i]) begin
                if (m_pend[i]) dropped = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_pdir[i] = nr[i];
                end
            end
        end
        if (clr) m_ovf = 1'b0;
        if (dropped) m_ovf = 1'b1;
        m_lvl  = m_lvl ^ (nr | nf);
        m_rise = nr;
        m_fall = nf;
        m_s2   = m_s1;
        m_s1   = raw;
    endtask

    initial begin
        for (int i = 0; i < W; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares visible state each cycle and pops the scoreboard on each accept.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("level", 32'(level_out), 32'(m_lvl));
                chk("rise", 32'(rise_pulse), 32'(m_rise));
                chk("fall", 32'(fall_pulse), 32'(m_fall));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("valid", 32'(evt_if.event_valid), 32'(m_v));
                if (evt_if.event_valid === 1'b1) begin
                    if (sbq.size() == 0) begin
                        chk("sb_has_item", 32'(sbq.size() != 0), 32'd1);
                    end else begin
                        chk("ev_idx", 32'(evt_if.event_idx), 32'(sbq[0].idx));
                        chk("ev_dir", 32'(evt_if.event_dir), 32'(sbq[0].dir));
                        if (rdy) void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; rdy = 1'b0; raw = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Single rise on channel 3: level/pulse after E5, event after E6, accepted at E7.
        raw[3] = 1'b1;
        cyc(6);
        chk("s1_level3", 32'(level_out[3]), 32'd1);
        chk("s1_rise3", 32'(rise_pulse[3]), 32'd1);
        cyc(1);
        chk("s1_rise3_off", 32'(rise_pulse[3]), 32'd0);
        chk("s1_valid", 32'(evt_if.event_valid), 32'd1);
        chk("s1_idx", 32'(evt_if.event_idx), 32'd3);
        chk("s1_dir", 32'(evt_if.event_dir), 32'd1);
        rdy = 1'b1;
        cyc(1);
        chk("s1_accepted", 32'(evt_if.event_valid), 32'd0);
        rdy = 1'b0;

        // Short glitch on channel 0 must not qualify.
        raw[0] = 1'b1;
        cyc(3);
        raw[0] = 1'b0;
        cyc(10);
        chk("glitch_level0", 32'(level_out[0]), 32'd0);

        // Simultaneous rises on channels 5 and 2 drain in index order.
        rdy = 1'b1;
        raw[5] = 1'b1;
        raw[2] = 1'b1;
        cyc(10);

        // Consumer stalled: rise, fall, rise on channel 1 overflows the pending slot.
        rdy = 1'b0;
        raw[1] = 1'b1;
        cyc(6);
        raw[1] = 1'b0;
        cyc(6);
        raw[1] = 1'b1;
        cyc(8);
        chk("s4_overflow", 32'(overflow), 32'd1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("s4_cleared", 32'(overflow), 32'd0);
        rdy = 1'b1;
        cyc(5);

        // Disabled block ignores channel 4 until re-enabled.
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            raw[4] = ~raw[4];
            cyc(2);
        end
        raw[4] = 1'b1;
        cyc(20);
        chk("en_off_level4", 32'(level_out[4]), 32'd0);
        en = 1'b1;
        cyc(3);
        chk("en_on_level4_early", 32'(level_out[4]), 32'd0);
        cyc(1);
        chk("en_on_level4", 32'(level_out[4]), 32'd1);
        cyc(4);

        // Reset with an event presented and a channel mid-count.
        rdy = 1'b0;
        raw[6] = 1'b1;
        cyc(7);
        raw[7] = 1'b1;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        chk("rst_valid", 32'(evt_if.event_valid), 32'd0);
        chk("rst_level", 32'(level_out), 32'd0);
        rst = 1'b0;
        cyc(DB + 1);
        chk("requal_early", 32'(level_out), 32'd0);
        cyc(1);
        chk("requal_level", 32'(level_out), 32'(raw));
        rdy = 1'b1;
        cyc(W + 2);

        // Random pin activity with random backpressure, enables, clears and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
            rdy = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 31) != 0);
            clr = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        // Drain with no new activity; every expected event must have been consumed.
        rst = 1'b0; en = 1'b0; clr = 1'b0; rdy = 1'b1;
        cyc(W + 4);
        chk("drain_valid", 32'(evt_if.event_valid), 32'd0);
        chk("drain_sb_empty", 32'(sbq.size()), 32'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
